// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arb_pkg
//  Description : Shared definitions for the serial transmit word arbiter.
//                Holds the FSM state type and named state constants. The
//                TAP controller assertions import the same package.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_arb_pkg;

   // Arbiter FSM states. The 2-bit encoding is explicit.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam state_t ST_IDLE  = IDLE;
   localparam state_t ST_SHIFT = SHIFT;
   localparam state_t ST_DONE  = DONE;

endpackage : tx_arb_pkg
`default_nettype wire

// File: rtl/tx_word_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin search. Starting just after
//                i_last_winner and wrapping modulo NUM_REQ, it selects the
//                first requester with its request bit set.
//  Ports       : i_req         - level requests, one bit per requester
//                i_last_winner - index of the previous winner
//                o_grant       - one-hot grant (all zero when i_req == 0)
//                o_grant_idx   - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_winner,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx
);

   always_comb begin
      logic             w_found;
      logic [IDX_W-1:0] w_idx;
      o_grant     = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_idx       = '0;
      // The offset runs from 1 to NUM_REQ, so the previous winner is
      // considered last. That ordering bounds any requester's wait to
      // NUM_REQ-1 transfers.
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = IDX_W'((int'(i_last_winner) + k) % NUM_REQ);
         if (!w_found && i_req[w_idx]) begin
            w_found          = 1'b1;
            o_grant[w_idx]   = 1'b1;
            o_grant_idx      = w_idx;
         end
      end
   end

endmodule : rr_picker
`default_nettype wire

// File: rtl/tx_word_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_word_arbiter
//  Description : Shares one serial transmit path among NUM_REQ requesters.
//                The winner is chosen by round-robin and its WIDTH-bit word
//                is captured. The word is then shifted out MSB-first, one
//                bit per shift_en cycle. A done pulse signals completion.
//                This block owns all bit counting, so requesters never track
//                word length.
//  Ports       : clk      - clock; all state changes on its rising edge
//                reset    - asynchronous active-low reset
//                req      - level requests, one bit per requester
//                data     - word of requester i is data[i*WIDTH +: WIDTH]
//                shift_en - advance one bit this cycle
//                ack      - one-hot, 1-cycle pulse on word capture
//                grant_id - index of the current or last winner
//                busy     - high from capture through the done cycle
//                tx_out   - registered serial data
//                done     - 1-cycle pulse after the last bit is driven
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_word_arbiter
   import tx_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 32,
   localparam int IDX_W   = $clog2(NUM_REQ),
   localparam int CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] data,
   input  logic                     shift_en,
   output logic [NUM_REQ-1:0]       ack,
   output logic [IDX_W-1:0]         grant_id,
   output logic                     busy,
   output logic                     tx_out,
   output logic                     done
);

   state_t               r_state;
   logic [WIDTH-1:0]     r_sreg;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_last;
   logic [NUM_REQ-1:0]   r_ack;
   logic [IDX_W-1:0]     r_grant;
   logic                 r_busy;
   logic                 r_tx;
   logic                 r_done;

   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_grant_idx;
   logic [WIDTH-1:0]     w_word;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .i_req         (req),
      .i_last_winner (r_last),
      .o_grant       (w_grant),
      .o_grant_idx   (w_grant_idx)
   );

   assign w_word = data[int'(w_grant_idx)*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);   // requester 0 gets first priority
         r_ack   <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_tx    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // ack and done are single-cycle pulses by default.
         r_ack  <= '0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_sreg  <= w_word;
                  r_cnt   <= CNT_W'(WIDTH);
                  r_ack   <= w_grant;
                  r_grant <= w_grant_idx;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // A zero count is never decremented. This guard keeps the
               // counter from wrapping.
               if (shift_en && (r_cnt != '0)) begin
                  r_tx   <= r_sreg[WIDTH-1];
                  r_sreg <= r_sreg << 1;
                  r_cnt  <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Round-robin history advances only when a transfer
               // completes. A reset mid-word leaves priority at requester 0.
               r_last  <= r_grant;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack      = r_ack;
   assign grant_id = r_grant;
   assign busy     = r_busy;
   assign tx_out   = r_tx;
   assign done     = r_done;

endmodule : tx_word_arbiter
`default_nettype wire

// File: tb/tb_tx_word_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_word_arbiter
//  Description : Scoreboard bench for tx_word_arbiter. A transfer-level
//                reference model predicts each captured word and winner
//                into a queue. A monitor checks the serial stream, ack,
//                busy and done against that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_word_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NR-1:0]   req = '0;
   logic [NR*W-1:0] data = '0;
   logic            shift_en = 1'b0;
   logic [NR-1:0]   ack;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            tx_out;
   logic            done;

   tx_word_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .data     (data),
      .shift_en (shift_en),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .tx_out   (tx_out),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int           idx;
      logic [W-1:0] word;
   } exp_t;

   exp_t sb_q[$];
   int   grant_log[$];
   int   done_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transfer level) ----------------
   // The model tracks only whether the path is free and how many bits of
   // the current word remain. A transfer occupies W enabled edges, then one
   // completion edge. The following edge may start a new capture.
   int m_last = NR - 1;
   int m_cur  = 0;
   int m_left = 0;
   bit m_free = 1'b1;
   bit m_fin  = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         m_last = NR - 1;
         m_left = 0;
         m_free = 1'b1;
         m_fin  = 1'b0;
         sb_q.delete();
      end else if (m_free) begin
         if (req != '0) begin
            int w;
            w = -1;
            for (int k = 1; k <= NR; k++)
               if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
            sb_q.push_back('{w, data[w*W +: W]});
            m_cur  = w;
            m_left = W;
            m_free = 1'b0;
         end
      end else if (m_left > 0) begin
         if (shift_en) begin
            m_left--;
            if (m_left == 0) m_fin = 1'b1;
         end
      end else if (m_fin) begin
         m_fin  = 1'b0;
         m_free = 1'b1;
         m_last = m_cur;
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      bit            active;
      bit            exp_busy;
      bit            exp_done;
      bit            clr_busy;
      logic          exp_tx;
      int            bitpos;
      logic [W-1:0]  cur;
      logic [NR-1:0] oh;
      exp_t          e;
      active = 0; exp_busy = 0; clr_busy = 0; exp_tx = 0; bitpos = 0; cur = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            chk("reset_outs", {ack, grant_id, busy, tx_out, done}, '0);
            active = 0; exp_busy = 0; clr_busy = 0; exp_tx = 0; bitpos = 0;
         end else begin
            exp_done = 0;
            if (clr_busy) begin
               exp_busy = 0;
               clr_busy = 0;
            end
            if (active && shift_en) begin
               exp_tx = cur[bitpos-1];
               bitpos--;
               if (bitpos == 0) begin
                  exp_done = 1;
                  active   = 0;
                  clr_busy = 1;
                  done_count++;
               end
            end
            if (ack != '0) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_ack", ack, '0);
               end else begin
                  e  = sb_q.pop_front();
                  oh = '0;
                  oh[e.idx] = 1'b1;
                  chk("ack_onehot", ack, oh);
                  chk("grant_id", grant_id, e.idx);
                  cur      = e.word;
                  bitpos   = W;
                  active   = 1;
                  exp_busy = 1;
                  grant_log.push_back(e.idx);
               end
            end else begin
               chk("missing_ack", sb_q.size(), 0);
            end
            chk("tx_out", tx_out, exp_tx);
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ack(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (ack != '0) ok = 1;
      end
      chk({"timeout_ack_", name}, ok, 1);
   endtask

   task automatic wait_done(input int target, input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (done_count >= target) ok = 1;
      end
      chk({"timeout_done_", name}, ok, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin : stim
      int gl;
      int dc;
      int lim;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Test 1: single word DEADBEEF from requester 0
      @(negedge clk);
      data[31:0] = 32'hDEADBEEF;
      req        = 4'b0001;
      shift_en   = 1'b1;
      wait_ack("t1");
      req = '0;
      wait_done(1, "t1");
      chk("t1_grant", grant_log[grant_log.size()-1], 0);

      // Test 2: all requesting, order 0,1,2,3,0 after reset
      do_reset();
      for (int i = 0; i < NR; i++) data[i*W +: W] = 32'h1000_0001 * (i + 3) ^ 32'hA5C3_0F96;
      gl  = grant_log.size();
      dc  = done_count;
      req = 4'b1111;
      wait_done(dc + 5, "t2");
      req = '0;
      for (int i = 0; i < 5; i++) chk("t2_rr_order", grant_log[gl+i], i % NR);

      // Test 3: stall after 10 bits for 5 cycles
      repeat (3) @(negedge clk);
      dc  = done_count;
      req = 4'b0010;
      wait_ack("t3");
      req = '0;
      repeat (10) @(negedge clk);
      shift_en = 1'b0;
      repeat (5) @(negedge clk);
      shift_en = 1'b1;
      wait_done(dc + 1, "t3");

      // Test 4: change data0 and drop req0 during the shift
      repeat (3) @(negedge clk);
      dc  = done_count;
      gl  = grant_log.size();
      data[31:0] = 32'h1234_5678;
      req = 4'b0001;
      wait_ack("t4");
      repeat (4) @(negedge clk);
      data[31:0] = 32'hFFFF_0000;
      req = '0;
      wait_done(dc + 1, "t4");
      repeat (5) @(negedge clk);
      chk("t4_single_ack", grant_log.size() - gl, 1);

      // Test 5: reset at bit 17, restart with only req2
      req = 4'b0001;
      wait_ack("t5");
      req = '0;
      repeat (16) @(negedge clk);
      dc    = done_count;
      reset = 1'b0;
      req   = 4'b0100;
      repeat (3) @(negedge clk);
      chk("t5_no_done", done_count, dc);
      gl    = grant_log.size();
      reset = 1'b1;
      wait_ack("t5b");
      req = '0;
      chk("t5_grant2", grant_log[gl], 2);
      wait_done(dc + 1, "t5b");

      // Test 6: wrap-around after requester 3 won
      do_reset();
      req = 4'b1000;
      wait_ack("t6");
      req = '0;
      wait_done(done_count + 1, "t6a");
      gl  = grant_log.size();
      dc  = done_count;
      req = 4'b1001;
      wait_done(dc + 2, "t6b");
      req = '0;
      chk("t6_wrap0", grant_log[gl], 0);
      chk("t6_then3", grant_log[gl+1], 3);

      // Random phase
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) req = NR'($urandom);
         shift_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0)
            data[$urandom_range(0, NR-1)*W +: W] = $urandom;
         if ($urandom_range(0, 799) == 0) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end

      // Drain the transfer in flight
      req      = '0;
      shift_en = 1'b1;
      lim      = 0;
      while (busy && lim < 100) begin
         @(negedge clk);
         lim++;
      end
      chk("drain_idle", busy, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_tx_word_arbiter
`default_nettype wire
